// File: rtl/acc_sample_sched.sv
// Periodic X/Y/Z sampling scheduler: prescaler + tick counter set the period, a req/ack FSM reads the axes.
// Optional per-request watchdog enabled by defining ACC_TIMEOUT_EN.
module acc_sample_sched #(
    parameter int DIV     = 4,
    parameter int TPS     = 4,
    parameter int DW      = 16,
    parameter int TIMEOUT = 32
) (
    input  logic          ck,
    input  logic          clr_n,
    input  logic          en,
    input  logic          ack,
    input  logic [DW-1:0] din,
    output logic          req,
    output logic [1:0]    axis,
    output logic [DW-1:0] x,
    output logic [DW-1:0] y,
    output logic [DW-1:0] z,
    output logic          valid,
    output logic          busy,
    output logic          ovr,
    output logic          err
);
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int TW = (TPS > 1) ? $clog2(TPS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        GAP  = 2'd2
    } state_t;

    logic [PW-1:0] pre_r;
    logic [TW-1:0] tcnt_r;
    logic          tick_s;
    logic          hit_s;

    state_t        state_r, state_nx;
    logic          req_r, req_nx;
    logic [1:0]    axis_r, axis_nx;
    logic [DW-1:0] x_r, x_nx, y_r, y_nx, z_r, z_nx;
    logic          valid_r, valid_nx;
    logic          busy_r, busy_nx;
    logic          ovr_r, ovr_nx;

`ifdef ACC_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT + 1);
    logic [WW-1:0] wd_r, wd_nx;
    logic          err_r, err_nx;
    assign err = err_r;
`else
    assign err = 1'b0;
`endif

    assign tick_s = en & (pre_r == PW'(DIV - 1));
    assign hit_s  = tick_s & (tcnt_r == TW'(TPS - 1));

    assign req   = req_r;
    assign axis  = axis_r;
    assign x     = x_r;
    assign y     = y_r;
    assign z     = z_r;
    assign valid = valid_r;
    assign busy  = busy_r;
    assign ovr   = ovr_r;

    // Prescaler and tick counter, both frozen while en is low.
    always_ff @(posedge ck or negedge clr_n) begin
        if (!clr_n) begin
            pre_r  <= '0;
            tcnt_r <= '0;
        end else if (en) begin
            if (tick_s) begin
                pre_r  <= '0;
                tcnt_r <= (tcnt_r == TW'(TPS - 1)) ? '0 : tcnt_r + TW'(1);
            end else begin
                pre_r  <= pre_r + PW'(1);
            end
        end
    end

    // Next-state and next-output logic of the read sequencer.
    always_comb begin
        state_nx = state_r;
        req_nx   = req_r;
        axis_nx  = axis_r;
        x_nx     = x_r;
        y_nx     = y_r;
        z_nx     = z_r;
        valid_nx = 1'b0;
        busy_nx  = busy_r;
        // A hit while a sequence is running is dropped and flagged.
        ovr_nx   = ovr_r | (hit_s & busy_r);
`ifdef ACC_TIMEOUT_EN
        wd_nx    = wd_r;
        err_nx   = err_r;
`endif
        case (state_r)
            IDLE: begin
                if (hit_s) begin
                    state_nx = REQ;
                    req_nx   = 1'b1;
                    axis_nx  = 2'd0;
                    busy_nx  = 1'b1;
`ifdef ACC_TIMEOUT_EN
                    wd_nx    = '0;
`endif
                end else begin
                    state_nx = IDLE;
                end
            end
            REQ: begin
                if (ack) begin
                    req_nx = 1'b0;
                    case (axis_r)
                        2'd0:    x_nx = din;
                        2'd1:    y_nx = din;
                        default: z_nx = din;
                    endcase
                    if (axis_r == 2'd2) begin
                        state_nx = IDLE;
                        busy_nx  = 1'b0;
                        valid_nx = 1'b1;
                        axis_nx  = 2'd0;
                    end else begin
                        state_nx = GAP;
                    end
                end else begin
`ifdef ACC_TIMEOUT_EN
                    if (wd_r == WW'(TIMEOUT - 1)) begin
                        state_nx = IDLE;
                        req_nx   = 1'b0;
                        busy_nx  = 1'b0;
                        axis_nx  = 2'd0;
                        err_nx   = 1'b1;
                    end else begin
                        wd_nx    = wd_r + WW'(1);
                    end
`else
                    state_nx = REQ;
`endif
                end
            end
            GAP: begin
                state_nx = REQ;
                req_nx   = 1'b1;
                axis_nx  = axis_r + 2'd1;
`ifdef ACC_TIMEOUT_EN
                wd_nx    = '0;
`endif
            end
            default: begin
                state_nx = IDLE;
                req_nx   = 1'b0;
                busy_nx  = 1'b0;
                axis_nx  = 2'd0;
            end
        endcase
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge ck or negedge clr_n) begin
        if (!clr_n) begin
            state_r <= IDLE;
            req_r   <= 1'b0;
            axis_r  <= 2'd0;
            x_r     <= '0;
            y_r     <= '0;
            z_r     <= '0;
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
            ovr_r   <= 1'b0;
`ifdef ACC_TIMEOUT_EN
            wd_r    <= '0;
            err_r   <= 1'b0;
`endif
        end else begin
            state_r <= state_nx;
            req_r   <= req_nx;
            axis_r  <= axis_nx;
            x_r     <= x_nx;
            y_r     <= y_nx;
            z_r     <= z_nx;
            valid_r <= valid_nx;
            busy_r  <= busy_nx;
            ovr_r   <= ovr_nx;
`ifdef ACC_TIMEOUT_EN
            wd_r    <= wd_nx;
            err_r   <= err_nx;
`endif
        end
    end
endmodule
